// File: rtl/pipeline_pkg.sv
// Shared LA32R pipeline definitions: bus widths, bus field offsets and ALU op indices.
package pipeline_pkg;

    localparam int DS2ES_W     = 148;
    localparam int ES2MS_W     = 71;
    localparam int ES_RF_ZIP_W = 39;

    localparam int ALU_OP_W    = 12;
    localparam int REG_ADDR_W  = 5;
    localparam int XLEN        = 32;

    // decode -> execute bus field offsets
    localparam int DS_ALU_OP_LSB   = 136;
    localparam int DS_RES_FROM_MEM = 135;
    localparam int DS_SRC1_LSB     = 103;
    localparam int DS_SRC2_LSB     = 71;
    localparam int DS_MEM_WE       = 70;
    localparam int DS_RF_WE        = 69;
    localparam int DS_WADDR_LSB    = 64;
    localparam int DS_RKD_LSB      = 32;
    localparam int DS_PC_LSB       = 0;

    // execute -> memory bus field offsets
    localparam int ES_RES_FROM_MEM = 70;
    localparam int ES_RF_WE        = 69;
    localparam int ES_WADDR_LSB    = 64;
    localparam int ES_RESULT_LSB   = 32;
    localparam int ES_PC_LSB       = 0;

    // one-hot ALU op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    function automatic logic [XLEN-1:0] sel_mask(input logic en);
        sel_mask = {XLEN{en}};
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 12-op one-hot ALU for the execute stage.
module alu
    import pipeline_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_src1,
    input  logic [XLEN-1:0]     alu_src2,
    output logic [XLEN-1:0]     alu_result
);

    logic [XLEN-1:0] add_res;
    logic [XLEN-1:0] sub_res;
    logic [XLEN-1:0] slt_res;
    logic [XLEN-1:0] sltu_res;
    logic [XLEN-1:0] and_res;
    logic [XLEN-1:0] nor_res;
    logic [XLEN-1:0] or_res;
    logic [XLEN-1:0] xor_res;
    logic [XLEN-1:0] sll_res;
    logic [XLEN-1:0] srl_res;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] lui_res;
    logic [4:0]      shamt;

    assign shamt    = alu_src2[4:0];
    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
    assign sltu_res = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
    assign and_res  = alu_src1 & alu_src2;
    assign nor_res  = ~(alu_src1 | alu_src2);
    assign or_res   = alu_src1 | alu_src2;
    assign xor_res  = alu_src1 ^ alu_src2;
    assign sll_res  = alu_src1 << shamt;
    assign srl_res  = alu_src1 >> shamt;
    assign sra_res  = $unsigned($signed(alu_src1) >>> shamt);
    assign lui_res  = alu_src2;

    // AND-OR mux: an all-zero op vector naturally yields zero
    always_comb begin
        alu_result = '0;
        alu_result = alu_result | (sel_mask(alu_op[ALU_ADD])  & add_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SUB])  & sub_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SLT])  & slt_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SLTU]) & sltu_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_AND])  & and_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_NOR])  & nor_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_OR])   & or_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_XOR])  & xor_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SLL])  & sll_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SRL])  & srl_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_SRA])  & sra_res);
        alu_result = alu_result | (sel_mask(alu_op[ALU_LUI])  & lui_res);
    end

endmodule

// File: rtl/ex_stage.sv
// LA32R execute stage: latches the decode bus, runs the ALU and issues data-SRAM requests.
// Optional build macro ES_ALIGN_CHECK_EN suppresses misaligned ld.w/st.w requests and raises es_ale.
module ex_stage
    import pipeline_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ds_to_es_valid,
    output logic                   es_allowin,
    input  logic [DS2ES_W-1:0]     ds_to_es_bus,
    input  logic                   ms_allowin,
    output logic                   es_to_ms_valid,
    output logic [ES2MS_W-1:0]     es_to_ms_bus,
    output logic [ES_RF_ZIP_W-1:0] es_rf_zip,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [XLEN-1:0]        data_sram_addr,
    output logic [XLEN-1:0]        data_sram_wdata,
    output logic                   es_ale
);

    logic                  es_valid;
    logic                  es_ready_go;
    logic [DS2ES_W-1:0]    ds_to_es_bus_r;

    logic [ALU_OP_W-1:0]   es_alu_op;
    logic                  es_res_from_mem;
    logic [XLEN-1:0]       es_alu_src1;
    logic [XLEN-1:0]       es_alu_src2;
    logic                  es_mem_we;
    logic                  es_rf_we;
    logic [REG_ADDR_W-1:0] es_rf_waddr;
    logic [XLEN-1:0]       es_rkd_value;
    logic [XLEN-1:0]       es_pc;
    logic [XLEN-1:0]       es_alu_result;

    logic                  mem_access;
    logic                  req_ok;

    assign es_ready_go    = 1'b1;
    assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid & es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_to_es_bus_r <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            ds_to_es_bus_r <= ds_to_es_bus;
        end
    end

    assign es_alu_op       = ds_to_es_bus_r[DS_ALU_OP_LSB +: ALU_OP_W];
    assign es_res_from_mem = ds_to_es_bus_r[DS_RES_FROM_MEM];
    assign es_alu_src1     = ds_to_es_bus_r[DS_SRC1_LSB +: XLEN];
    assign es_alu_src2     = ds_to_es_bus_r[DS_SRC2_LSB +: XLEN];
    assign es_mem_we       = ds_to_es_bus_r[DS_MEM_WE];
    assign es_rf_we        = ds_to_es_bus_r[DS_RF_WE];
    assign es_rf_waddr     = ds_to_es_bus_r[DS_WADDR_LSB +: REG_ADDR_W];
    assign es_rkd_value    = ds_to_es_bus_r[DS_RKD_LSB +: XLEN];
    assign es_pc           = ds_to_es_bus_r[DS_PC_LSB +: XLEN];

    alu u_alu (
        .alu_op     (es_alu_op),
        .alu_src1   (es_alu_src1),
        .alu_src2   (es_alu_src2),
        .alu_result (es_alu_result)
    );

    assign es_to_ms_bus = {es_res_from_mem, es_rf_we, es_rf_waddr, es_alu_result, es_pc};

    // Write-enable is qualified so stale register contents never look like a pending write
    assign es_rf_zip = {es_res_from_mem, es_rf_we & es_valid, es_rf_waddr, es_alu_result};

    assign mem_access = es_res_from_mem | es_mem_we;

`ifdef ES_ALIGN_CHECK_EN
    assign es_ale = es_valid & mem_access & (es_alu_result[1:0] != 2'b00);
    assign req_ok = ~es_ale;
`else
    assign es_ale = 1'b0;
    assign req_ok = 1'b1;
`endif

    // Request fires only on the handoff cycle, so a stalled instruction issues exactly once
    assign data_sram_en    = es_valid & mem_access & ms_allowin & req_ok;
    assign data_sram_we    = {4{es_valid & es_mem_we & ms_allowin & req_ok}};
    assign data_sram_addr  = es_alu_result;
    assign data_sram_wdata = es_rkd_value;

endmodule
